// File: rtl/mux_pkg.sv
// Shared constants and helpers for the arbitrated N-to-1 registered multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Constant-evaluable ceil(log2(value)), never less than 1 so index ports stay legal.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational grant selection: fixed lowest-index priority or round-robin from ptr.
module rr_picker
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [N-1:0]     gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] masked_req;
  logic [N-1:0] pool;

  // Channels at or above ptr get first chance; if none request, the search wraps to 0.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign upper_mask[gi] = (gi >= int'(ptr));
    end
  endgenerate

  assign masked_req = req & upper_mask;
  assign pool       = ((mode == MODE_RR) && (|masked_req)) ? masked_req : req;
  assign any        = |req;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pool[i]) begin
        gnt_onehot    = '0;
        gnt_onehot[i] = 1'b1;
        gnt_idx       = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr_reg.sv
// N-input WIDTH-bit multiplexer with internal arbitration and a registered valid/ready output.
module mux_nx1_rr_reg
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic [WIDTH-1:0] word [N];
  logic [SEL_W-1:0] ptr_reg;
  logic [SEL_W-1:0] ptr_next;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SEL_W-1:0] out_sel_reg;

  logic [N-1:0]     gnt_onehot;
  logic [SEL_W-1:0] gnt_idx;
  logic             any;
  logic             load;
  logic             accept;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign word[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_picker #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_picker (
    .req        (in_valid),
    .ptr        (ptr_reg),
    .mode       (mode),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  // The output register can take a new word when empty or being drained this cycle.
  assign load     = ~out_valid_reg | out_ready;
  assign accept   = load & any & ~rst;
  assign in_ready = accept ? gnt_onehot : '0;
  assign ptr_next = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      ptr_reg       <= '0;
    end else if (load) begin
      if (any) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= word[gnt_idx];
        out_sel_reg   <= gnt_idx;
        if (mode == MODE_RR) begin
          ptr_reg <= ptr_next;
        end
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_mux_nx1_rr_reg.sv
// Self-checking bench: hand-derived vector table plus randomized traffic against a reference model.
module tb_mux_nx1_rr_reg;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  mux_nx1_rr_reg #(.N(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       mode;
    bit [3:0] vld;
    bit       ordy;
    bit [3:0] rdy;
    bit       ov;
    bit [1:0] sel;
    bit [7:0] data;
  } vec_t;

  typedef struct {
    int       sel;
    bit [7:0] data;
  } word_t;

  vec_t  tbl[$];
  word_t sb[$];

  int vectors;
  int miscompares;

  // Reference model: conceptual state of the output register and rotation pointer.
  int       m_ptr;
  bit       m_ov;
  bit [7:0] m_data;
  int       m_sel;
  logic [3:0] act_rdy;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit md, input bit [3:0] v, input bit [31:0] d, input bit ordy);
    int       g;
    bit       load;
    int       idx;
    bit [3:0] exp_rdy;
    bit       pre_ov;
    bit [7:0] pre_data;
    int       pre_sel;
    bit [7:0] chan [4];
    @(negedge clk);
    rst = r; mode = md; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    for (int c = 0; c < 4; c++) chan[c] = d[c*8 +: 8];
    g    = -1;
    load = !m_ov || ordy;
    if (!r && load) begin
      for (int k = 0; k < 4; k++) begin
        idx = md ? (m_ptr + k) % 4 : k;
        if (v[idx] && g < 0) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    act_rdy  = in_ready;
    pre_ov   = out_valid;
    pre_data = out_data;
    pre_sel  = int'(out_sel);
    check("in_ready", int'(in_ready), int'(exp_rdy));
    @(posedge clk);
    #1;
    if (r) begin
      m_ov = 0; m_data = 0; m_sel = 0; m_ptr = 0;
      sb.delete();
    end else begin
      if (pre_ov && ordy) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL sb_underflow: word sel=%0d data=0x%0h delivered, expected none pending", pre_sel, pre_data);
        end else begin
          check("sb_sel", pre_sel, sb[0].sel);
          check("sb_data", int'(pre_data), int'(sb[0].data));
          void'(sb.pop_front());
        end
      end
      if (load) begin
        if (g >= 0) begin
          m_ov = 1; m_data = chan[g]; m_sel = g;
          sb.push_back('{sel: g, data: chan[g]});
          if (md) m_ptr = (g == 3) ? 0 : g + 1;
        end else begin
          m_ov = 0;
        end
      end
    end
    check("out_valid", int'(out_valid), int'(m_ov));
    check("out_data", int'(out_data), int'(m_data));
    check("out_sel", int'(out_sel), m_sel);
  endtask

  function automatic void add(bit r, bit md, bit [3:0] v, bit o, bit [3:0] rd, bit ov, bit [1:0] s, bit [7:0] dt);
    tbl.push_back('{rst: r, mode: md, vld: v, ordy: o, rdy: rd, ov: ov, sel: s, data: dt});
  endfunction

  initial begin
    vectors = 0; miscompares = 0;
    m_ptr = 0; m_ov = 0; m_data = 0; m_sel = 0;
    rst = 1; mode = 0; in_valid = 0; in_data = 0; out_ready = 0;

    // Reset with all channels requesting
    add(1, 0, 4'hF, 1, 4'b0000, 0, 0, 8'h00);
    add(1, 0, 4'hF, 1, 4'b0000, 0, 0, 8'h00);
    // Fixed priority: ch1 always beats ch3
    for (int i = 0; i < 3; i++) add(0, 0, 4'b1010, 1, 4'b0010, 1, 1, 8'hA1);
    // Round-robin over all four channels, twice
    for (int i = 0; i < 8; i++) add(0, 1, 4'hF, 1, 4'(1 << (i % 4)), 1, 2'(i % 4), 8'hA0 + 8'(i % 4));
    // Wrap/skip from ptr=3 with channels 0 and 2
    add(0, 1, 4'b0100, 1, 4'b0100, 1, 2, 8'hA2);
    add(0, 1, 4'b0101, 1, 4'b0001, 1, 0, 8'hA0);
    add(0, 1, 4'b0101, 1, 4'b0100, 1, 2, 8'hA2);
    add(0, 1, 4'b0101, 1, 4'b0001, 1, 0, 8'hA0);
    // Backpressure holding the ch2 word, then release continues from ptr=3
    add(0, 1, 4'b0101, 1, 4'b0100, 1, 2, 8'hA2);
    for (int i = 0; i < 3; i++) add(0, 1, 4'hF, 0, 4'b0000, 1, 2, 8'hA2);
    add(0, 1, 4'hF, 1, 4'b1000, 1, 3, 8'hA3);
    // Drain, reload, stall, reset while stalled, then ptr must be back at 0
    add(0, 1, 4'b0000, 1, 4'b0000, 0, 3, 8'hA3);
    add(0, 1, 4'b0010, 1, 4'b0010, 1, 1, 8'hA1);
    add(0, 1, 4'b0000, 0, 4'b0000, 1, 1, 8'hA1);
    add(1, 1, 4'hF, 0, 4'b0000, 0, 0, 8'h00);
    add(0, 1, 4'hF, 1, 4'b0001, 1, 0, 8'hA0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].mode, tbl[i].vld, 32'hA3A2A1A0, tbl[i].ordy);
      check("tbl_in_ready", int'(act_rdy), int'(tbl[i].rdy));
      check("tbl_out_valid", int'(out_valid), int'(tbl[i].ov));
      check("tbl_out_sel", int'(out_sel), int'(tbl[i].sel));
      check("tbl_out_data", int'(out_data), int'(tbl[i].data));
    end

    // Randomized traffic with occasional mode flips and resets
    begin
      bit md;
      md = 1;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(15) == 0) md = ~md;
        step($urandom_range(49) == 0, md, 4'($urandom), $urandom, $urandom_range(3) != 0);
      end
    end

    check("sb_residual", sb.size(), m_ov ? 1 : 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
